issue_window: RTL and testbench

- Eight-entry, in-order, compacting instruction window that sits directly upstream of the four-slot RAW/WAR hazard checker.
- Accepts one decoded instruction per cycle from rename/decode and presents the four oldest entries to the checker as slots 1..4, with slot 1 the oldest.
- Takes the checker's per-slot issue flags back, retires every flagged entry at the clock edge, and compacts the survivors toward the head with age order preserved.

---
 rtl/issue_window.sv | 160 ++++++++++++++++
 tb/tb_issue_window.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/issue_window.sv
// Eight-entry in-order compacting instruction window feeding the four-slot hazard checker.
// Flagged head slots retire on the clock edge and the survivors close ranks toward entry 0.
module issue_window #(
    parameter int DEPTH = 8,
    parameter int DES_W = 4,
    parameter int SRC_W = 4,
    parameter int OP_W  = 6,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [DES_W-1:0] enq_des,
    input  logic [SRC_W-1:0] enq_s1,
    input  logic [SRC_W-1:0] enq_s2,
    input  logic [OP_W-1:0]  enq_op,
    input  logic             flush,
    input  logic             stall,
    output logic             slot1_vld,
    output logic [DES_W-1:0] slot1_des,
    output logic [SRC_W-1:0] slot1_s1,
    output logic [SRC_W-1:0] slot1_s2,
    output logic [OP_W-1:0]  slot1_op,
    output logic             slot2_vld,
    output logic [DES_W-1:0] slot2_des,
    output logic [SRC_W-1:0] slot2_s1,
    output logic [SRC_W-1:0] slot2_s2,
    output logic [OP_W-1:0]  slot2_op,
    output logic             slot3_vld,
    output logic [DES_W-1:0] slot3_des,
    output logic [SRC_W-1:0] slot3_s1,
    output logic [SRC_W-1:0] slot3_s2,
    output logic [OP_W-1:0]  slot3_op,
    output logic             slot4_vld,
    output logic [DES_W-1:0] slot4_des,
    output logic [SRC_W-1:0] slot4_s1,
    output logic [SRC_W-1:0] slot4_s2,
    output logic [OP_W-1:0]  slot4_op,
    input  logic             issue_flag_1,
    input  logic             issue_flag_2,
    input  logic             issue_flag_3,
    input  logic             issue_flag_4,
    output logic [3:0]       iss_mask,
    output logic [CNT_W-1:0] count
);

    logic [DES_W-1:0] des_q [DEPTH];
    logic [SRC_W-1:0] s1_q  [DEPTH];
    logic [SRC_W-1:0] s2_q  [DEPTH];
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [DES_W-1:0] des_d [DEPTH];
    logic [SRC_W-1:0] s1_d  [DEPTH];
    logic [SRC_W-1:0] s2_d  [DEPTH];
    logic [OP_W-1:0]  op_d  [DEPTH];

    logic [CNT_W-1:0] cnt_q, cnt_d, pop;
    logic [3:0]       flags, slot_vld;
    logic [DEPTH-1:0] live, retire;
    logic [IDX_W-1:0] enq_idx;
    logic             accept;

    assign flags = {issue_flag_4, issue_flag_3, issue_flag_2, issue_flag_1};

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            live[j] = cnt_q > CNT_W'(j);
        end
    end

    assign slot_vld = live[3:0];
    assign iss_mask = flags & slot_vld & {4{~stall & ~flush}};
    assign retire   = DEPTH'(iss_mask);
    assign pop      = CNT_W'(iss_mask[0]) + CNT_W'(iss_mask[1])
                    + CNT_W'(iss_mask[2]) + CNT_W'(iss_mask[3]);

    // Depends on the registered count only, so issue flags never reach enq_rdy.
    assign enq_rdy = cnt_q < CNT_W'(DEPTH);
    assign accept  = enq_vld & enq_rdy & ~flush;
    assign enq_idx = IDX_W'(cnt_q - pop);

    always_comb begin
        logic [IDX_W-1:0] gap;
        gap   = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            des_d[i] = '0;
            s1_d[i]  = '0;
            s2_d[i]  = '0;
            op_d[i]  = '0;
        end
        if (flush) begin
            cnt_d = '0;
        end else begin
            // Each survivor moves down by the number of retired entries below it.
            for (int j = 0; j < DEPTH; j++) begin
                if (retire[j]) begin
                    gap = gap + IDX_W'(1);
                end else if (live[j]) begin
                    des_d[IDX_W'(j) - gap] = des_q[j];
                    s1_d[IDX_W'(j) - gap]  = s1_q[j];
                    s2_d[IDX_W'(j) - gap]  = s2_q[j];
                    op_d[IDX_W'(j) - gap]  = op_q[j];
                end
            end
            if (accept) begin
                des_d[enq_idx] = enq_des;
                s1_d[enq_idx]  = enq_s1;
                s2_d[enq_idx]  = enq_s2;
                op_d[enq_idx]  = enq_op;
            end
            cnt_d = cnt_q - pop + CNT_W'(accept);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                des_q[i] <= '0;
                s1_q[i]  <= '0;
                s2_q[i]  <= '0;
                op_q[i]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                des_q[i] <= des_d[i];
                s1_q[i]  <= s1_d[i];
                s2_q[i]  <= s2_d[i];
                op_q[i]  <= op_d[i];
            end
        end
    end

    assign count = cnt_q;

    assign slot1_vld = slot_vld[0];
    assign slot1_des = slot_vld[0] ? des_q[0] : '0;
    assign slot1_s1  = slot_vld[0] ? s1_q[0]  : '0;
    assign slot1_s2  = slot_vld[0] ? s2_q[0]  : '0;
    assign slot1_op  = slot_vld[0] ? op_q[0]  : '0;
    assign slot2_vld = slot_vld[1];
    assign slot2_des = slot_vld[1] ? des_q[1] : '0;
    assign slot2_s1  = slot_vld[1] ? s1_q[1]  : '0;
    assign slot2_s2  = slot_vld[1] ? s2_q[1]  : '0;
    assign slot2_op  = slot_vld[1] ? op_q[1]  : '0;
    assign slot3_vld = slot_vld[2];
    assign slot3_des = slot_vld[2] ? des_q[2] : '0;
    assign slot3_s1  = slot_vld[2] ? s1_q[2]  : '0;
    assign slot3_s2  = slot_vld[2] ? s2_q[2]  : '0;
    assign slot3_op  = slot_vld[2] ? op_q[2]  : '0;
    assign slot4_vld = slot_vld[3];
    assign slot4_des = slot_vld[3] ? des_q[3] : '0;
    assign slot4_s1  = slot_vld[3] ? s1_q[3]  : '0;
    assign slot4_s2  = slot_vld[3] ? s2_q[3]  : '0;
    assign slot4_op  = slot_vld[3] ? op_q[3]  : '0;

endmodule

// File: tb/tb_issue_window.sv
// Bench for issue_window: directed scenarios followed by random traffic, all checked
// against an age-ordered queue model of the window contents.
module tb_issue_window;

    logic       clk, rst_n;
    logic       enq_vld, enq_rdy, flush, stall;
    logic [3:0] enq_des, enq_s1, enq_s2;
    logic [5:0] enq_op;
    logic [3:0] flags, iss_mask;
    logic [3:0] count;
    logic       slot1_vld, slot2_vld, slot3_vld, slot4_vld;
    logic [3:0] slot1_des, slot2_des, slot3_des, slot4_des;
    logic [3:0] slot1_s1, slot2_s1, slot3_s1, slot4_s1;
    logic [3:0] slot1_s2, slot2_s2, slot3_s2, slot4_s2;
    logic [5:0] slot1_op, slot2_op, slot3_op, slot4_op;

    issue_window dut (
        .clk(clk), .rst_n(rst_n),
        .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_des(enq_des),
        .enq_s1(enq_s1), .enq_s2(enq_s2), .enq_op(enq_op),
        .flush(flush), .stall(stall),
        .slot1_vld(slot1_vld), .slot1_des(slot1_des), .slot1_s1(slot1_s1), .slot1_s2(slot1_s2), .slot1_op(slot1_op),
        .slot2_vld(slot2_vld), .slot2_des(slot2_des), .slot2_s1(slot2_s1), .slot2_s2(slot2_s2), .slot2_op(slot2_op),
        .slot3_vld(slot3_vld), .slot3_des(slot3_des), .slot3_s1(slot3_s1), .slot3_s2(slot3_s2), .slot3_op(slot3_op),
        .slot4_vld(slot4_vld), .slot4_des(slot4_des), .slot4_s1(slot4_s1), .slot4_s2(slot4_s2), .slot4_op(slot4_op),
        .issue_flag_1(flags[0]), .issue_flag_2(flags[1]), .issue_flag_3(flags[2]), .issue_flag_4(flags[3]),
        .iss_mask(iss_mask), .count(count)
    );

    // Window contents as {des, s1, s2, op}, oldest at index 0.
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  last_iss;
    logic        last_rdy;

    logic [3:0]  obs_vld;
    logic [17:0] obs_slot [4];
    assign obs_vld     = {slot4_vld, slot3_vld, slot2_vld, slot1_vld};
    assign obs_slot[0] = {slot1_des, slot1_s1, slot1_s2, slot1_op};
    assign obs_slot[1] = {slot2_des, slot2_s1, slot2_s2, slot2_op};
    assign obs_slot[2] = {slot3_des, slot3_s1, slot3_s2, slot3_op};
    assign obs_slot[3] = {slot4_des, slot4_s1, slot4_s2, slot4_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void check_all();
        int         n;
        logic [3:0] exp_mask;
        n = exp_q.size();
        check("count", 32'(count), 32'(n));
        check("enq_rdy", 32'(enq_rdy), 32'(n < 8));
        for (int k = 0; k < 4; k++) begin
            exp_mask[k] = flags[k] && (k < n) && !stall && !flush;
            check($sformatf("slot%0d_vld", k + 1), 32'(obs_vld[k]), 32'(k < n));
            check($sformatf("slot%0d_fields", k + 1), 32'(obs_slot[k]), (k < n) ? 32'(exp_q[k]) : 32'd0);
        end
        check("iss_mask", 32'(iss_mask), 32'(exp_mask));
    endfunction

    // Called at a falling edge: drive, check pre-edge outputs, cross the rising edge, update model.
    task automatic cycle(input logic v, input logic [3:0] d, input logic fl,
                         input logic st, input logic [3:0] f);
        logic [17:0] item;
        logic        acc;
        enq_vld = v;
        enq_des = d;
        enq_s1  = 4'($urandom_range(0, 15));
        enq_s2  = 4'($urandom_range(0, 15));
        enq_op  = 6'($urandom_range(0, 63));
        flush   = fl;
        stall   = st;
        flags   = f;
        #1;
        check_all();
        last_iss = iss_mask;
        last_rdy = enq_rdy;
        item = {d, enq_s1, enq_s2, enq_op};
        acc  = v && (exp_q.size() < 8) && !fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (f[k] && !st && k < exp_q.size()) exp_q.delete(k);
            end
            if (acc) exp_q.push_back(item);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        enq_vld = 1'b0;
        flush   = 1'b0;
        stall   = 1'b0;
        flags   = 4'b0000;
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        enq_vld = 1'b0; enq_des = '0; enq_s1 = '0; enq_s2 = '0; enq_op = '0;
        flush   = 1'b0; stall = 1'b0;
        flags   = 4'b1111;
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Empty window ignores issue flags.
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'b1111);

        // Three enqueues become visible one cycle after acceptance.
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 4'd2, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 4'd3, 1'b0, 1'b0, 4'b0000);
        idle();
        check("plan1_count", 32'(count), 32'd3);
        check("plan1_slot4_vld", 32'(slot4_vld), 32'd0);
        check("plan1_slot1_des", 32'(slot1_des), 32'd1);
        check("plan1_slot3_des", 32'(slot3_des), 32'd3);

        // Retire with a hole: slots 1 and 3 leave, slot 2 stays.
        for (int i = 4; i <= 6; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'b0101);
        check("plan2_iss", 32'(last_iss), 32'b0101);
        idle();
        check("plan2_count", 32'(count), 32'd4);
        check("plan2_order", {16'd0, slot1_des, slot2_des, slot3_des, slot4_des}, 32'h2456);

        // Fill to full; the held instruction waits until space frees a cycle later.
        for (int i = 7; i <= 10; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 4'd11, 1'b0, 1'b0, 4'b0000);
        check("plan3_full_rdy", 32'(last_rdy), 32'd0);
        cycle(1'b1, 4'd11, 1'b0, 1'b0, 4'b0001);
        check("plan3_retire_rdy", 32'(last_rdy), 32'd0);
        check("plan3_count7", 32'(count), 32'd7);
        check("plan3_rdy_again", 32'(enq_rdy), 32'd1);
        cycle(1'b1, 4'd11, 1'b0, 1'b0, 4'b0000);
        check("plan3_count8", 32'(count), 32'd8);

        // Down to five, then retire four while enqueueing.
        cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'b0111);
        check("plan4_count5", 32'(count), 32'd5);
        cycle(1'b1, 4'd9, 1'b0, 1'b0, 4'b1111);
        idle();
        check("plan4_count2", 32'(count), 32'd2);
        check("plan4_slot1_des", 32'(slot1_des), 32'd11);
        check("plan4_slot2_des", 32'(slot2_des), 32'd9);

        // Stall blocks retirement; flush drops the same-cycle enqueue.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'b1111);
        check("plan5_stall_iss", 32'(last_iss), 32'd0);
        check("plan5_stall_count", 32'(count), 32'd6);
        cycle(1'b1, 4'd7, 1'b1, 1'b0, 4'b1111);
        check("plan5_flush_iss", 32'(last_iss), 32'd0);
        idle();
        check("plan5_flush_count", 32'(count), 32'd0);
        check("plan5_flush_vld", 32'(obs_vld), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 4'b0000);
        idle();
        check("plan6_pre_count", 32'(count), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("plan6_rst_count", 32'(count), 32'd0);
        check("plan6_rst_vld", 32'(obs_vld), 32'd0);
        check("plan6_rst_rdy", 32'(enq_rdy), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic; the second half retires rarely so the window fills up.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            if (c >= 300 && $urandom_range(0, 3) != 0) f = 4'b0000;
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0, f);
        end
        idle();
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
